decoder_3bit: RTL and testbench
===============================

DECODER_3BIT -- requirements
Module: decoder_3bit

Interface
REQ-001 SHALL have parameter IN_W, default 3; select width.
REQ-002 SHALL have parameter OUT_W, default 8; output width, fixed to 2**IN_W; any other value is an elaboration error.
REQ-003 SHALL have parameter REGISTERED, default 1.
  - 1: registered outputs.
  - 0: combinational outputs; clk/rst_n unused except by valid.
REQ-004 SHALL have port clk, input, 1; rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1; decode enable.
REQ-007 SHALL have port inputs, input, IN_W; binary select code.
REQ-008 SHALL have port outputs, output, OUT_W; one-hot decode result, bit k set iff decoded code == k.
REQ-009 SHALL have port valid, output, 1; high while outputs holds a decode captured in the previous cycle.

Function
REQ-010 SHALL, with REGISTERED=1 and en=1 at a rising clk edge, load outputs with 1 shifted left by inputs and set valid=1.
REQ-011 SHALL, with REGISTERED=1 and en=0 at a rising clk edge, hold outputs unchanged and clear valid to 0.
REQ-012 SHALL have latency of exactly one clk cycle from sampled inputs/en to outputs/valid when REGISTERED=1.
REQ-013 SHALL, with REGISTERED=0, drive outputs = (en ? 1<<inputs : 0) combinationally.
  - valid SHALL then be a registered copy of en.
REQ-014 SHALL keep exactly one bit of outputs high after any enabled decode; code 0 -> 8'b0000_0001, code 7 -> 8'b1000_0000.
REQ-015 SHALL accept a new code every cycle, back-to-back, with no bubbles.
REQ-016 SHALL decode all 2**IN_W codes; no code is illegal and no wrap-around occurs.
REQ-017 SHALL keep outputs all-zero from reset until the first enabled edge; all-zero is the only legal non-one-hot value.

Reset
REQ-018 SHALL, on rst_n low, immediately clear outputs to all-zero and valid to 0, independent of clk.
REQ-019 SHALL hold outputs=0 and valid=0 while rst_n is low, regardless of en and inputs.
REQ-020 SHALL resume normal operation at the first rising clk edge after rst_n deasserts.
REQ-021 SHALL discard any in-flight decode when reset is asserted mid-operation.

Structure
REQ-022 SHALL place the IN_W default and a decode function (code -> one-hot) in a shared package decoder_pkg, for reuse by other blocks.
REQ-023 SHALL be implemented as a single module without sub-modules; the decode logic is the package function.
REQ-024 SHALL include an elaboration-time check that OUT_W == 2**IN_W.
REQ-025 SHALL include an optional simulation assertion that outputs is zero or one-hot at every edge.

Verification
REQ-026 Reset: rst_n=0 with en=1, inputs=5 -> outputs=8'h00, valid=0 immediately and throughout.
REQ-027 Sweep: en=1, inputs stepped 0..7, each held 100 ns -> one cycle after each change, outputs = 01,02,04,08,10,20,40,80 (hex), valid=1.
REQ-028 Hold: decode inputs=3 (outputs=8'h08), then en=0 with inputs=6 -> outputs stays 8'h08, valid=0 next cycle.
REQ-029 Back-to-back: inputs = 7,0,7 on consecutive enabled cycles -> outputs = 80,01,80 on consecutive cycles.
REQ-030 Mid-op reset: pulse rst_n low between clock edges while outputs=8'h20 -> outputs=8'h00 at once; first enabled edge after release with inputs=1 -> 8'h02.
REQ-031 Combinational (REGISTERED=0): en=1, inputs=4 -> outputs=8'h10 with no clock; en=0 -> outputs=8'h00.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared decode helpers: default select width and a code -> one-hot function
// sized for the widest decoder any block is expected to build.
package decoder_pkg;
  localparam int DEC_IN_W      = 3;
  localparam int DEC_MAX_IN_W  = 6;
  localparam int DEC_MAX_OUT_W = 2**DEC_MAX_IN_W;

  // Callers cast the result down to their own 2**IN_W width.
  function automatic logic [DEC_MAX_OUT_W-1:0] decode_onehot(input logic [DEC_MAX_IN_W-1:0] code);
    return DEC_MAX_OUT_W'(1) << code;
  endfunction
endpackage

// File: rtl/decoder_3bit.sv
// Binary-to-one-hot decoder with optional output register and a valid flag
// that marks a decode captured on the previous edge.
module decoder_3bit
  import decoder_pkg::*;
#(
  parameter int IN_W       = DEC_IN_W,
  parameter int OUT_W      = 2**IN_W,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  inputs,
  output logic [OUT_W-1:0] outputs,
  output logic             valid
);

  if (OUT_W != 2**IN_W) begin : g_bad_out_w
    $error("decoder_3bit: OUT_W must equal 2**IN_W");
  end
  if (IN_W > DEC_MAX_IN_W || IN_W < 1) begin : g_bad_in_w
    $error("decoder_3bit: IN_W out of range for decoder_pkg");
  end

  logic [OUT_W-1:0] dec;
  assign dec = OUT_W'(decode_onehot(DEC_MAX_IN_W'(inputs)));

  // valid tracks the sampled enable in both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= 1'b0;
    else        valid <= en;
  end

  if (REGISTERED) begin : g_reg
    logic [OUT_W-1:0] outputs_q;
    // Disabled edges hold the last decode; only reset returns to all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  outputs_q <= '0;
      else if (en) outputs_q <= dec;
    end
    assign outputs = outputs_q;
  end else begin : g_comb
    assign outputs = en ? dec : '0;
  end

`ifndef SYNTHESIS
  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(outputs))
    else $error("decoder_3bit: outputs not zero/one-hot");
`endif

endmodule

// File: tb/tb_decoder_3bit.sv
// Directed bench: table-driven decode vectors on the registered build plus
// hand sequences for reset, mid-operation reset and the combinational build.
module tb_decoder_3bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, en_c;
  logic [2:0] inputs, inputs_c;
  logic [7:0] outputs, outputs_c;
  logic       valid, valid_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_3bit #(.IN_W(3), .OUT_W(8), .REGISTERED(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .inputs(inputs),
    .outputs(outputs), .valid(valid)
  );

  decoder_3bit #(.IN_W(3), .OUT_W(8), .REGISTERED(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .en(en_c), .inputs(inputs_c),
    .outputs(outputs_c), .valid(valid_c)
  );

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] code;
    int         hold;
    logic [7:0] exp_out;
    logic       exp_vld;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"sweep0", 1'b1, 3'd0, 10, 8'h01, 1'b1};
    vecs[1]  = '{"sweep1", 1'b1, 3'd1, 10, 8'h02, 1'b1};
    vecs[2]  = '{"sweep2", 1'b1, 3'd2, 10, 8'h04, 1'b1};
    vecs[3]  = '{"sweep3", 1'b1, 3'd3, 10, 8'h08, 1'b1};
    vecs[4]  = '{"sweep4", 1'b1, 3'd4, 10, 8'h10, 1'b1};
    vecs[5]  = '{"sweep5", 1'b1, 3'd5, 10, 8'h20, 1'b1};
    vecs[6]  = '{"sweep6", 1'b1, 3'd6, 10, 8'h40, 1'b1};
    vecs[7]  = '{"sweep7", 1'b1, 3'd7, 10, 8'h80, 1'b1};
    vecs[8]  = '{"hold_load", 1'b1, 3'd3, 1, 8'h08, 1'b1};
    vecs[9]  = '{"hold_dis",  1'b0, 3'd6, 3, 8'h08, 1'b0};
    vecs[10] = '{"b2b_7a",    1'b1, 3'd7, 1, 8'h80, 1'b1};
    vecs[11] = '{"b2b_0",     1'b1, 3'd0, 1, 8'h01, 1'b1};
    vecs[12] = '{"b2b_7b",    1'b1, 3'd7, 1, 8'h80, 1'b1};

    // Reset asserted with an active request: nothing may come through.
    rst_n = 1'b0; en = 1'b1; inputs = 3'd5; en_c = 1'b0; inputs_c = 3'd0;
    #1;
    chk("rst_imm_out", outputs, 8'h00);
    chk("rst_imm_vld", {7'b0, valid}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_out", outputs, 8'h00);
    chk("rst_hold_vld", {7'b0, valid}, 8'h00);

    // Release with en low: outputs stay zero until the first enabled edge.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out", outputs, 8'h00);
    chk("post_rst_vld", {7'b0, valid}, 8'h00);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      en = vecs[i].en; inputs = vecs[i].code;
      for (int c = 0; c < vecs[i].hold; c++) begin
        @(posedge clk); #1;
        if (c == 0 || c == vecs[i].hold - 1) begin
          chk({vecs[i].name, "_out"}, outputs, vecs[i].exp_out);
          chk({vecs[i].name, "_vld"}, {7'b0, valid}, {7'b0, vecs[i].exp_vld});
        end
      end
    end

    // Mid-operation reset pulsed between edges.
    @(negedge clk);
    en = 1'b1; inputs = 3'd5;
    @(posedge clk); #1;
    chk("mid_pre_out", outputs, 8'h20);
    @(negedge clk);
    inputs = 3'd1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", outputs, 8'h00);
    chk("mid_rst_vld", {7'b0, valid}, 8'h00);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_after_out", outputs, 8'h02);
    chk("mid_after_vld", {7'b0, valid}, 8'h01);

    // Combinational build: outputs follow en/inputs without an edge.
    @(negedge clk);
    en = 1'b0;
    en_c = 1'b1; inputs_c = 3'd4;
    #1;
    chk("comb_en_out", outputs_c, 8'h10);
    inputs_c = 3'd2;
    #1;
    chk("comb_chg_out", outputs_c, 8'h04);
    @(posedge clk); #1;
    chk("comb_vld_hi", {7'b0, valid_c}, 8'h01);
    @(negedge clk);
    en_c = 1'b0;
    #1;
    chk("comb_dis_out", outputs_c, 8'h00);
    @(posedge clk); #1;
    chk("comb_vld_lo", {7'b0, valid_c}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
